id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; SHALL be >= 32.
REQ-002 Parameter REG_AW, default 5: register-file address width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  inst_i/inst_addr_i valid from IF.
REQ-007 in_ready  out  1  stage accepts input this cycle.
REQ-008 inst_i  in  32  instruction word.
REQ-009 inst_addr_i  in  XLEN  instruction address.
REQ-010 rs1_addr_o / rs2_addr_o  out  REG_AW each  combinational regfile read addresses.
REQ-011 rs1_data_i / rs2_data_i  in  XLEN each  combinational regfile read data.
REQ-012 flush_i  in  1  discard held and incoming instruction.
REQ-013 out_valid  out  1  registered ID/EX payload valid.
REQ-014 out_ready  in  1  EX accepts payload.
REQ-015 inst_o  out  32, inst_addr_o  out  XLEN  registered copies.
REQ-016 op_num1_o, op_num2_o, imm_o  out  XLEN each  registered operands/immediate.
REQ-017 rd_addr_o  out  REG_AW, reg_wen_o  out  1, mem_rd_o  out  1, illegal_o  out  1  registered.

Function
REQ-018 in_ready SHALL be (!out_valid || out_ready) && !stall && !flush_i; capture on in_valid && in_ready.
REQ-019 Capture latency SHALL be exactly one cycle; payload SHALL stay stable while out_valid && !out_ready.
REQ-020 Handoff (out_valid && out_ready) with no capture SHALL clear out_valid next cycle.
REQ-021 rs1_addr_o/rs2_addr_o SHALL be 0 when the decoded instruction does not use that field.
REQ-022 Immediates SHALL be sign-extended to XLEN (I, S, B, J); U-imm = inst_i[31:12]<<12, sign-extended.
REQ-023 OP-IMM (all func3, legal shift func7): op1=rs1, op2=I-imm, imm=I-imm, reg_wen=1.
REQ-024 OP (all func3; func7 0000000, or 0100000 for ADD/SUB, SRL/SRA): op1=rs1, op2=rs2, reg_wen=1.
REQ-025 BRANCH (func3 000,001,100-111): op1=rs1, op2=rs2, imm=B-imm, reg_wen=0.
REQ-026 JAL: op1=inst_addr, op2=J-imm, reg_wen=1; JALR (func3 000): op1=rs1, op2=I-imm, reg_wen=1.
REQ-027 LUI: op1=U-imm, op2=0; AUIPC: op1=inst_addr, op2=U-imm; both reg_wen=1.
REQ-028 LOAD (func3 000,001,010,100,101): op1=rs1, op2=I-imm, mem_rd=1, reg_wen=1.
REQ-029 STORE (func3 000-010): op1=rs1, op2=rs2 data, imm=S-imm, reg_wen=0.
REQ-030 rd==0 SHALL force reg_wen_o=0.
REQ-031 Any other encoding SHALL set illegal_o=1, all operand/addr/enable fields 0, and still pass with out_valid=1.
REQ-032 stall SHALL be out_valid && mem_rd_o && rd_addr_o!=0 && rd_addr_o matches a used rs of inst_i && in_valid; one bubble results.
REQ-033 flush_i SHALL clear out_valid next cycle regardless of out_ready/in_valid; flush beats capture and stall.

Reset
REQ-034 On rst: out_valid=0, all registered outputs 0, illegal_o=0.
REQ-035 rst mid-stall or mid-backpressure SHALL drop the held payload; in_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-036 Opcode, func3, func7 constants SHALL live in shared defines.v, extended with the new opcodes.
REQ-037 Combinational decode SHALL be sub-module id_decode; id_stage holds handshake, hazard and ID/EX register.

Verification
REQ-038 ADDI 0xFFF00093 at pc 0x100 -> next cycle out_valid=1, op1=0, op2=0xFFFFFFFF, rd=1, reg_wen=1.
REQ-039 BEQ 0x00208463 -> rs1_addr=1, rs2_addr=2, imm_o=8, reg_wen_o=0.
REQ-040 Payload held, out_ready=0 for 3 cycles -> outputs unchanged, in_ready=0 throughout.
REQ-041 LW 0x0000A283 then ADD 0x00528333, out_ready=1 -> one out_valid=0 bubble, then ADD issued.
REQ-042 flush_i=1 with in_valid=1 -> out_valid=0 next cycle, instruction not captured.
REQ-043 inst 0xFFFFFFFF -> illegal_o=1, reg_wen_o=0, out_valid=1.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Purpose: shared decode constants, selector enums and the control-flag payload
//          used by id_decode and id_stage.
// Contents: RV32 opcode/func3/func7 constants, operand selector enums,
//           id_ctrl_t (reg_wen/mem_rd/illegal), OP-IMM and OP legality helpers.
package id_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_JALR = 3'b000;
  localparam logic [F3_W-1:0] F3_SW   = 3'b010;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_IMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM} op2_sel_e;

  typedef struct packed {
    logic reg_wen;
    logic mem_rd;
    logic illegal;
  } id_ctrl_t;

  // Shift-immediates constrain func7; every other OP-IMM func3 is legal.
  function automatic logic op_imm_legal(input logic [F3_W-1:0] f3, input logic [F7_W-1:0] f7);
    if (f3 == F3_SLL) return f7 == F7_BASE;
    if (f3 == F3_SR)  return (f7 == F7_BASE) || (f7 == F7_ALT);
    return 1'b1;
  endfunction

  // The alternate func7 only exists for SUB and SRA.
  function automatic logic op_legal(input logic [F3_W-1:0] f3, input logic [F7_W-1:0] f7);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
  endfunction

endpackage

// File: rtl/id_decode.sv
// Purpose: combinational RV32 instruction decode for the ID stage.
// Ports:   inst_i/inst_addr_i       instruction and its address
//          rs1/rs2_addr_o           regfile read addresses (0 when field unused)
//          rs1/rs2_data_i           regfile read data
//          op1_o/op2_o/imm_o        operands and sign-extended immediate
//          rd_addr_o, ctrl_o        destination and control flags
module id_decode
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [INST_W-1:0] inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output id_ctrl_t          ctrl_o
);

  logic [OPC_W-1:0] w_opc;
  logic [F3_W-1:0]  w_f3;
  logic [F7_W-1:0]  w_f7;
  logic signed [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic w_use_rs1, w_use_rs2, w_wr_rd;
  op1_sel_e w_op1_sel;
  op2_sel_e w_op2_sel;

  assign w_opc = inst_i[6:0];
  assign w_f3  = inst_i[14:12];
  assign w_f7  = inst_i[31:25];

  assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign w_imm_u = {inst_i[31:12], 12'b0};

  // Format decode: selects only, no regfile data, so the read-address path stays acyclic.
  always_comb begin
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_wr_rd        = 1'b0;
    w_op1_sel      = OP1_ZERO;
    w_op2_sel      = OP2_ZERO;
    imm_o          = '0;
    ctrl_o.mem_rd  = 1'b0;
    ctrl_o.illegal = 1'b0;
    unique case (w_opc)
      OPC_OP_IMM: if (op_imm_legal(w_f3, w_f7)) begin
        w_use_rs1 = 1'b1; w_wr_rd = 1'b1;
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; imm_o = XLEN'(w_imm_i);
      end else ctrl_o.illegal = 1'b1;
      OPC_OP: if (op_legal(w_f3, w_f7)) begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_wr_rd = 1'b1;
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2;
      end else ctrl_o.illegal = 1'b1;
      OPC_BRANCH: if (w_f3[2:1] != 2'b01) begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2; imm_o = XLEN'(w_imm_b);
      end else ctrl_o.illegal = 1'b1;
      OPC_JAL: begin
        w_wr_rd = 1'b1;
        w_op1_sel = OP1_PC; w_op2_sel = OP2_IMM; imm_o = XLEN'(w_imm_j);
      end
      OPC_JALR: if (w_f3 == F3_JALR) begin
        w_use_rs1 = 1'b1; w_wr_rd = 1'b1;
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; imm_o = XLEN'(w_imm_i);
      end else ctrl_o.illegal = 1'b1;
      OPC_LUI: begin
        w_wr_rd = 1'b1; w_op1_sel = OP1_IMM; imm_o = XLEN'(w_imm_u);
      end
      OPC_AUIPC: begin
        w_wr_rd = 1'b1;
        w_op1_sel = OP1_PC; w_op2_sel = OP2_IMM; imm_o = XLEN'(w_imm_u);
      end
      OPC_LOAD: if ((w_f3 != 3'b011) && (w_f3[2:1] != 2'b11)) begin
        w_use_rs1 = 1'b1; w_wr_rd = 1'b1; ctrl_o.mem_rd = 1'b1;
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; imm_o = XLEN'(w_imm_i);
      end else ctrl_o.illegal = 1'b1;
      OPC_STORE: if (w_f3 <= F3_SW) begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2; imm_o = XLEN'(w_imm_s);
      end else ctrl_o.illegal = 1'b1;
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

  assign rs1_addr_o = w_use_rs1 ? REG_AW'(inst_i[19:15]) : '0;
  assign rs2_addr_o = w_use_rs2 ? REG_AW'(inst_i[24:20]) : '0;
  assign rd_addr_o  = w_wr_rd   ? REG_AW'(inst_i[11:7])  : '0;
  // Writes to x0 are architecturally discarded.
  assign ctrl_o.reg_wen = w_wr_rd && (rd_addr_o != '0);

  // Operand muxing from the selects and regfile data.
  always_comb begin
    op1_o = '0;
    op2_o = '0;
    unique case (w_op1_sel)
      OP1_RS1: op1_o = rs1_data_i;
      OP1_PC:  op1_o = inst_addr_i;
      OP1_IMM: op1_o = imm_o;
      default: op1_o = '0;
    endcase
    unique case (w_op2_sel)
      OP2_RS2: op2_o = rs2_data_i;
      OP2_IMM: op2_o = imm_o;
      default: op2_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Purpose: ID pipeline stage: IF->ID handshake, load-use hazard detection,
//          flush handling and the registered ID/EX payload.
// Ports:   clk, rst (sync, active-high); in_valid/in_ready/inst_i/inst_addr_i from IF;
//          rs*_addr_o/rs*_data_i to/from the regfile; flush_i;
//          out_valid/out_ready plus registered inst/addr/operands/imm/rd/flags to EX.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   op_num1_o,
  output logic [XLEN-1:0]   op_num2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen_o,
  output logic              mem_rd_o,
  output logic              illegal_o
);

  logic [XLEN-1:0]   w_op1, w_op2, w_imm;
  logic [REG_AW-1:0] w_rd;
  id_ctrl_t          w_ctrl;
  logic              w_stall, w_capture;

  logic              r_out_valid;
  logic [INST_W-1:0] r_inst;
  logic [XLEN-1:0]   r_inst_addr, r_op1, r_op2, r_imm;
  logic [REG_AW-1:0] r_rd;
  id_ctrl_t          r_ctrl;

  id_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode (
    .inst_i     (inst_i),
    .inst_addr_i(inst_addr_i),
    .rs1_addr_o (rs1_addr_o),
    .rs2_addr_o (rs2_addr_o),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .op1_o      (w_op1),
    .op2_o      (w_op2),
    .imm_o      (w_imm),
    .rd_addr_o  (w_rd),
    .ctrl_o     (w_ctrl)
  );

  // Load-use: the held load's data is not available yet; unused rs fields read as 0, never matching rd!=0.
  assign w_stall = r_out_valid && r_ctrl.mem_rd && (r_rd != '0) && in_valid &&
                   ((r_rd == rs1_addr_o) || (r_rd == rs2_addr_o));
  assign in_ready  = (!r_out_valid || out_ready) && !w_stall && !flush_i;
  assign w_capture = in_valid && in_ready;

  // ID/EX register; flush wins over capture, capture wins over plain handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_inst      <= '0;
      r_inst_addr <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_inst      <= inst_i;
      r_inst_addr <= inst_addr_i;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_imm       <= w_imm;
      r_rd        <= w_rd;
      r_ctrl      <= w_ctrl;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign inst_o      = r_inst;
  assign inst_addr_o = r_inst_addr;
  assign op_num1_o   = r_op1;
  assign op_num2_o   = r_op2;
  assign imm_o       = r_imm;
  assign rd_addr_o   = r_rd;
  assign reg_wen_o   = r_ctrl.reg_wen;
  assign mem_rd_o    = r_ctrl.mem_rd;
  assign illegal_o   = r_ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Purpose: directed self-checking bench for id_stage; regfile modelled as x0=0, xN=0xA000_0000|N.
module tb_id_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, flush_i, out_valid, out_ready;
  logic [31:0]       inst_i, inst_o;
  logic [XLEN-1:0]   inst_addr_i, inst_addr_o, rs1_data_i, rs2_data_i;
  logic [XLEN-1:0]   op_num1_o, op_num2_o, imm_o;
  logic [REG_AW-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic              reg_wen_o, mem_rd_o, illegal_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] rsd(input logic [REG_AW-1:0] a);
    return (a == '0) ? '0 : (32'hA000_0000 | 32'(a));
  endfunction

  assign rs1_data_i = rsd(rs1_addr_o);
  assign rs2_data_i = rsd(rs2_addr_o);

  id_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op_num1_o(op_num1_o), .op_num2_o(op_num2_o), .imm_o(imm_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .mem_rd_o(mem_rd_o), .illegal_o(illegal_o)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
    inst_i = 32'h0; inst_addr_i = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    checks++; if ({inst_o, op_num1_o, op_num2_o, imm_o} !== '0) begin failures++; $display("FAIL reset_payload got=%0h exp=0", {inst_o, op_num1_o, op_num2_o, imm_o}); end
    checks++; if ({rd_addr_o, reg_wen_o, mem_rd_o, illegal_o} !== '0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", {rd_addr_o, reg_wen_o, mem_rd_o, illegal_o}); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    in_valid = 1'b1; inst_i = 32'hFFF00093; inst_addr_i = 32'h100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_in_ready got=%0h exp=1", in_ready); end
    checks++; if ({rs1_addr_o, rs2_addr_o} !== '0) begin failures++; $display("FAIL addi_rs_addr got=%0h exp=0", {rs1_addr_o, rs2_addr_o}); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
    checks++; if (op_num1_o !== 32'h0) begin failures++; $display("FAIL addi_op1 got=%0h exp=0", op_num1_o); end
    checks++; if (op_num2_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_op2 got=%0h exp=ffffffff", op_num2_o); end
    checks++; if (rd_addr_o !== 5'd1 || reg_wen_o !== 1'b1) begin failures++; $display("FAIL addi_rd got=%0h/%0h exp=1/1", rd_addr_o, reg_wen_o); end
    checks++; if (inst_addr_o !== 32'h100) begin failures++; $display("FAIL addi_pc got=%0h exp=100", inst_addr_o); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_handoff got=%0h exp=0", out_valid); end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; inst_i = 32'h00208463; inst_addr_i = 32'h200; out_ready = 1'b1;
    #1;
    checks++; if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2) begin failures++; $display("FAIL beq_rs got=%0d/%0d exp=1/2", rs1_addr_o, rs2_addr_o); end
    step();
    in_valid = 1'b0;
    checks++; if (imm_o !== 32'd8) begin failures++; $display("FAIL beq_imm got=%0h exp=8", imm_o); end
    checks++; if (reg_wen_o !== 1'b0) begin failures++; $display("FAIL beq_wen got=%0h exp=0", reg_wen_o); end
    checks++; if (op_num1_o !== 32'hA0000001 || op_num2_o !== 32'hA0000002) begin failures++; $display("FAIL beq_ops got=%0h/%0h exp=a0000001/a0000002", op_num1_o, op_num2_o); end
    step();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; inst_i = 32'h00500113; inst_addr_i = 32'h300; out_ready = 1'b0;
    step();
    inst_i = 32'h00700193; inst_addr_i = 32'h304;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", c, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || op_num2_o !== 32'd5 || rd_addr_o !== 5'd2 || inst_addr_o !== 32'h300) begin
        failures++; $display("FAIL bp_hold[%0d] got=v%0h op2=%0h rd=%0d pc=%0h exp=v1 op2=5 rd=2 pc=300", c, out_valid, op_num2_o, rd_addr_o, inst_addr_o); end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || op_num2_o !== 32'd7 || rd_addr_o !== 5'd3) begin
      failures++; $display("FAIL bp_release got=v%0h op2=%0h rd=%0d exp=v1 op2=7 rd=3", out_valid, op_num2_o, rd_addr_o); end
    step();
  endtask

  task automatic test_load_use();
    int bound;
    in_valid = 1'b1; inst_i = 32'h0000A283; inst_addr_i = 32'h400; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || mem_rd_o !== 1'b1 || rd_addr_o !== 5'd5 || reg_wen_o !== 1'b1) begin
      failures++; $display("FAIL lw_issue got=v%0h mrd=%0h rd=%0d wen=%0h exp=1/1/5/1", out_valid, mem_rd_o, rd_addr_o, reg_wen_o); end
    inst_i = 32'h00528333; inst_addr_i = 32'h404;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got=%0h exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_resume got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || inst_o !== 32'h00528333 || rd_addr_o !== 5'd6 || mem_rd_o !== 1'b0) begin
      failures++; $display("FAIL lu_add got=v%0h inst=%0h rd=%0d mrd=%0h exp=v1 00528333 6 0", out_valid, inst_o, rd_addr_o, mem_rd_o); end
    checks++; if (op_num1_o !== 32'hA0000005 || op_num2_o !== 32'hA0000005) begin failures++; $display("FAIL lu_add_ops got=%0h/%0h exp=a0000005", op_num1_o, op_num2_o); end
    bound = 0;
    while (out_valid === 1'b1 && bound < 4) begin step(); bound++; end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; inst_i = 32'h00500113; inst_addr_i = 32'h500; out_ready = 1'b0;
    step();
    flush_i = 1'b1; inst_i = 32'h00700193; inst_addr_i = 32'h504;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    step();
    flush_i = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0h exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || inst_addr_o === 32'h504) begin failures++; $display("FAIL flush_nocap got=v%0h pc=%0h exp=v0 pc!=504", out_valid, inst_addr_o); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; inst_i = 32'h00500113; inst_addr_i = 32'h600; out_ready = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || op_num2_o !== '0 || rd_addr_o !== '0) begin
      failures++; $display("FAIL rst_mid got=v%0h op2=%0h rd=%0d exp=0/0/0", out_valid, op_num2_o, rd_addr_o); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_decode_table();
    logic [31:0] t_inst [10] = '{32'hFFFFFFFF, 32'h123452B7, 32'hFFFFF317, 32'h00100013, 32'h008000EF,
                                 32'h0020A223, 32'h40209033, 32'h4020D193, 32'h0020A463, 32'h004100E7};
    logic [31:0] t_pc   [10] = '{32'h700, 32'h704, 32'h708, 32'h70C, 32'h710,
                                 32'h714, 32'h718, 32'h71C, 32'h720, 32'h724};
    logic [31:0] t_op1  [10] = '{32'h0, 32'h12345000, 32'h708, 32'h0, 32'h710,
                                 32'hA0000001, 32'h0, 32'hA0000001, 32'h0, 32'hA0000002};
    logic [31:0] t_op2  [10] = '{32'h0, 32'h0, 32'hFFFFF000, 32'h1, 32'h8,
                                 32'hA0000002, 32'h0, 32'h402, 32'h0, 32'h4};
    logic [31:0] t_imm  [10] = '{32'h0, 32'h12345000, 32'hFFFFF000, 32'h1, 32'h8,
                                 32'h4, 32'h0, 32'h402, 32'h0, 32'h4};
    logic [4:0]  t_rd   [10] = '{5'd0, 5'd5, 5'd6, 5'd0, 5'd1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd1};
    logic [2:0]  t_flg  [10] = '{3'b001, 3'b100, 3'b100, 3'b000, 3'b100,
                                 3'b000, 3'b001, 3'b100, 3'b001, 3'b100};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; inst_i = t_inst[i]; inst_addr_i = t_pc[i];
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || inst_o !== t_inst[i]) begin failures++; $display("FAIL dec_valid[%0d] got=v%0h inst=%0h exp=v1 inst=%0h", i, out_valid, inst_o, t_inst[i]); end
      checks++; if (op_num1_o !== t_op1[i] || op_num2_o !== t_op2[i] || imm_o !== t_imm[i]) begin
        failures++; $display("FAIL dec_ops[%0d] got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, op_num1_o, op_num2_o, imm_o, t_op1[i], t_op2[i], t_imm[i]); end
      checks++; if (rd_addr_o !== t_rd[i] || {reg_wen_o, mem_rd_o, illegal_o} !== t_flg[i]) begin
        failures++; $display("FAIL dec_ctrl[%0d] got=rd%0d flg%b exp=rd%0d flg%b", i, rd_addr_o, {reg_wen_o, mem_rd_o, illegal_o}, t_rd[i], t_flg[i]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_backpressure();
    test_load_use();
    test_flush();
    test_reset_mid();
    test_decode_table();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
